// File: rtl/config_rx_pkg.sv
// config_rx_pkg: shared encodings for the
// configuration serial receiver.
package config_rx_pkg;

  typedef enum logic [2:0] {
    INICIAL  = 3'd0,
    START    = 3'd1,
    DADOS    = 3'd2,
    PARIDADE = 3'd3,
    STOP     = 3'd4,
    FIM      = 3'd5
  } rx_state_t;

  localparam int   DATA_BITS  = 8;
  localparam logic STOP_VALUE = 1'b1;
  localparam logic IDLE_VALUE = 1'b1;

endpackage

// File: rtl/config_rx_tick.sv
// config_rx_tick: bit-period counter with
// half-bit or full-bit terminal count.
module config_rx_tick #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic half,
  output logic tick
);

  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] T_FULL =
    W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0] T_HALF =
    W'(CLKS_PER_BIT / 2 - 1);

  logic [W-1:0] cnt_q;

  assign tick = (cnt_q ==
    (half ? T_HALF : T_FULL));

  // count, wrap at terminal, restart on clear
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      cnt_q <= '0;
    else if (clear || tick)
      cnt_q <= '0;
    else
      cnt_q <= cnt_q + W'(1);
  end

endmodule

// File: rtl/config_serial_rx.sv
// config_serial_rx: start/8 data/parity/stop
// frame receiver feeding the config manager.
module config_serial_rx
  import config_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT   = 5208,
  parameter bit PARIDADE_IMPAR = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] dado,
  output logic                 fim_recepcao,
  output logic                 paridade_ok,
  output logic                 erro_frame,
  output logic                 ocupado
);

  localparam int IW = $clog2(DATA_BITS);

  rx_state_t state_q, state_d;
  logic [1:0] sync_q;
  logic rx_s;
  logic tick, clear, half;
  logic [IW-1:0] idx_q;
  logic bit_last;
  logic [DATA_BITS-1:0] shr_q;
  logic par_q;

  assign rx_s = sync_q[1];
  assign bit_last = (idx_q == IW'(DATA_BITS - 1));
  assign half = (state_q == START);
  assign clear = (state_d != state_q) ||
                 (state_q == INICIAL);

  config_rx_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clock(clock),
    .reset(reset),
    .clear(clear),
    .half (half),
    .tick (tick)
  );

  // two-flop synchronizer, idles high
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      sync_q <= {IDLE_VALUE, IDLE_VALUE};
    else
      sync_q <= {sync_q[0], rx_serial};
  end

  // state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      state_q <= INICIAL;
    else
      state_q <= state_d;
  end

  // next-state and pulse/busy outputs
  always_comb begin
    state_d      = state_q;
    fim_recepcao = 1'b0;
    ocupado      = 1'b1;
    unique case (state_q)
      INICIAL: begin
        ocupado = 1'b0;
        if (!rx_s)
          state_d = START;
      end
      START: begin
        if (tick)
          state_d = rx_s ? INICIAL : DADOS;
      end
      DADOS: begin
        if (tick && bit_last)
          state_d = PARIDADE;
      end
      PARIDADE: begin
        if (tick)
          state_d = STOP;
      end
      STOP: begin
        if (tick)
          state_d = FIM;
      end
      FIM: begin
        fim_recepcao = 1'b1;
        state_d      = INICIAL;
      end
      default: state_d = INICIAL;
    endcase
  end

  // shift register, parity capture, results
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx_q       <= '0;
      shr_q       <= '0;
      par_q       <= 1'b0;
      dado        <= '0;
      paridade_ok <= 1'b0;
      erro_frame  <= 1'b0;
    end else begin
      if (state_q == INICIAL)
        idx_q <= '0;
      if (state_q == DADOS && tick) begin
        shr_q <= {rx_s, shr_q[DATA_BITS-1:1]};
        idx_q <= idx_q + IW'(1);
      end
      if (state_q == PARIDADE && tick)
        par_q <= rx_s;
      if (state_q == STOP && tick) begin
        dado        <= shr_q;
        paridade_ok <=
          ((^{shr_q, par_q}) == PARIDADE_IMPAR) &&
          (rx_s == STOP_VALUE);
        erro_frame  <= (rx_s != STOP_VALUE);
      end
    end
  end

endmodule

// File: tb/tb_config_serial_rx.sv
// tb_config_serial_rx: directed frames with
// hand-computed expectations.
module tb_config_serial_rx;

  localparam int C = 16;
  localparam int H = C / 2;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       rx_serial = 1'b1;
  logic [7:0] dado;
  logic       fim_recepcao;
  logic       paridade_ok;
  logic       erro_frame;
  logic       ocupado;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_t0 = 0;

  int         q_t[$];
  logic [7:0] q_d[$];
  logic       q_p[$];
  logic       q_e[$];

  logic [7:0] b2b_d[5] = '{8'h12, 8'h34,
                           8'h56, 8'h78, 8'h9A};
  logic       b2b_p[5] = '{1'b0, 1'b1,
                           1'b0, 1'b0, 1'b0};

  config_serial_rx #(
    .CLKS_PER_BIT  (C),
    .PARIDADE_IMPAR(1'b0)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .rx_serial   (rx_serial),
    .dado        (dado),
    .fim_recepcao(fim_recepcao),
    .paridade_ok (paridade_ok),
    .erro_frame  (erro_frame),
    .ocupado     (ocupado)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (fim_recepcao) begin
      q_t.push_back(cyc);
      q_d.push_back(dado);
      q_p.push_back(paridade_ok);
      q_e.push_back(erro_frame);
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic clr_q();
    q_t.delete();
    q_d.delete();
    q_p.delete();
    q_e.delete();
  endtask

  task automatic put_bit(input logic b);
    rx_serial = b;
    repeat (C) @(negedge clock);
  endtask

  task automatic send(input logic [7:0] d,
                      input logic p,
                      input logic s);
    last_t0 = cyc + 1;
    put_bit(1'b0);
    for (int i = 0; i < 8; i++)
      put_bit(d[i]);
    put_bit(p);
    put_bit(s);
    rx_serial = 1'b1;
  endtask

  initial begin
    int t0;
    repeat (3) @(negedge clock);
    chk("rst_dado", dado, 8'h00);
    chk("rst_fim", fim_recepcao, 1'b0);
    chk("rst_pok", paridade_ok, 1'b0);
    chk("rst_err", erro_frame, 1'b0);
    chk("rst_ocup", ocupado, 1'b0);
    reset = 1'b1;
    repeat (10) @(negedge clock);

    clr_q();
    send(8'h5A, 1'b0, 1'b1);
    repeat (30) @(negedge clock);
    chk("ok_n", q_d.size(), 1);
    chk("ok_time", q_t[0], last_t0 + 2 + H + 10 * C);
    chk("ok_dado", q_d[0], 8'h5A);
    chk("ok_pok", q_p[0], 1'b1);
    chk("ok_err", q_e[0], 1'b0);
    chk("ok_hold", dado, 8'h5A);
    chk("ok_idle", ocupado, 1'b0);

    clr_q();
    send(8'h5A, 1'b1, 1'b1);
    repeat (30) @(negedge clock);
    chk("par_n", q_d.size(), 1);
    chk("par_dado", q_d[0], 8'h5A);
    chk("par_pok", q_p[0], 1'b0);
    chk("par_err", q_e[0], 1'b0);

    clr_q();
    send(8'hFF, 1'b0, 1'b0);
    repeat (40) @(negedge clock);
    chk("stp_n", q_d.size(), 1);
    chk("stp_dado", q_d[0], 8'hFF);
    chk("stp_pok", q_p[0], 1'b0);
    chk("stp_err", q_e[0], 1'b1);

    clr_q();
    t0 = cyc + 1;
    rx_serial = 1'b0;
    repeat (3) @(negedge clock);
    rx_serial = 1'b1;
    while (cyc < t0 + H + 1) @(negedge clock);
    chk("gl_busy", ocupado, 1'b1);
    @(negedge clock);
    chk("gl_free", ocupado, 1'b0);
    repeat (40) @(negedge clock);
    chk("gl_n", q_d.size(), 0);
    chk("gl_dado", dado, 8'hFF);

    clr_q();
    for (int k = 0; k < 5; k++)
      send(b2b_d[k], b2b_p[k], 1'b1);
    repeat (30) @(negedge clock);
    chk("b2b_n", q_d.size(), 5);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("b2b_dado%0d", k),
          q_d[k], b2b_d[k]);
      chk($sformatf("b2b_pok%0d", k),
          q_p[k], 1'b1);
      chk($sformatf("b2b_err%0d", k),
          q_e[k], 1'b0);
    end

    clr_q();
    put_bit(1'b0);
    put_bit(1'b1);
    put_bit(1'b1);
    put_bit(1'b0);
    put_bit(1'b0);
    rx_serial = 1'b0;
    repeat (H) @(negedge clock);
    chk("ra_busy", ocupado, 1'b1);
    reset = 1'b0;
    #1;
    chk("ra_dado", dado, 8'h00);
    chk("ra_fim", fim_recepcao, 1'b0);
    chk("ra_ocup", ocupado, 1'b0);
    chk("ra_pok", paridade_ok, 1'b0);
    @(negedge clock);
    rx_serial = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (40) @(negedge clock);
    chk("ra_n", q_d.size(), 0);
    chk("ra_idle", ocupado, 1'b0);

    clr_q();
    send(8'h3C, 1'b0, 1'b1);
    repeat (30) @(negedge clock);
    chk("nx_n", q_d.size(), 1);
    chk("nx_time", q_t[0], last_t0 + 2 + H + 10 * C);
    chk("nx_dado", q_d[0], 8'h3C);
    chk("nx_pok", q_p[0], 1'b1);
    chk("nx_err", q_e[0], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
